// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with priority writes, optional bypass and busy scoreboard
module regfile_mp #(
  parameter int unsigned XLen      = 32,
  parameter int unsigned NReg      = 32,
  parameter int unsigned NRegWidth = $clog2(NReg),
  parameter int unsigned NRead     = 4,
  parameter int unsigned NWrite    = 2,
  parameter int unsigned Bypass    = 1,
  parameter int unsigned CntWidth  = $clog2(NReg + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NRead-1:0][NRegWidth-1:0]    raddr_i,
  output logic [NRead-1:0][XLen-1:0]         rdata_o,
  output logic [NRead-1:0]                   rbusy_o,
  input  logic [NWrite-1:0]                  we_i,
  input  logic [NWrite-1:0][NRegWidth-1:0]   waddr_i,
  input  logic [NWrite-1:0][XLen-1:0]        wdata_i,
  input  logic                               rsv_i,
  input  logic [NRegWidth-1:0]               rsv_addr_i,
  output logic [CntWidth-1:0]                busy_cnt_o,
  output logic                               werr_o
);
  logic [NReg-1:0][XLen-1:0] r_mem;
  logic [NReg-1:0]           r_busy;
  logic [CntWidth-1:0]       r_cnt;
  logic                      r_werr;
  logic [NReg-1:0]           w_wr_hit;
  logic [NReg-1:0][XLen-1:0] w_wr_data;
  logic [NReg-1:0]           w_busy_nxt;
  logic [CntWidth-1:0]       w_cnt_nxt;
  logic                      w_werr;
  // per-register write decode; ascending scan lets the highest enabled port win
  always_comb begin
    w_wr_hit  = '0;
    w_wr_data = '0;
    for (int r = 1; r < NReg; r++) begin
      for (int w = 0; w < NWrite; w++) begin
        if (we_i[w] && waddr_i[w] == NRegWidth'(r)) begin
          w_wr_hit[r]  = 1'b1;
          w_wr_data[r] = wdata_i[w];
        end
      end
    end
  end
  // flag two enabled ports colliding on the same nonzero register
  always_comb begin
    w_werr = 1'b0;
    for (int i = 0; i < NWrite; i++) begin
      for (int j = 0; j < NWrite; j++) begin
        if (j > i && we_i[i] && we_i[j] && waddr_i[i] == waddr_i[j] && waddr_i[i] != '0) w_werr = 1'b1;
      end
    end
  end
  // next busy state: a new reservation supersedes a completing write to the same register
  always_comb begin
    w_busy_nxt = '0;
    for (int r = 1; r < NReg; r++) begin
      w_busy_nxt[r] = (rsv_i && rsv_addr_i == NRegWidth'(r)) ? 1'b1 : w_wr_hit[r] ? 1'b0 : r_busy[r];
    end
  end
  // population count of the post-update busy vector
  always_comb begin
    w_cnt_nxt = '0;
    for (int r = 0; r < NReg; r++) w_cnt_nxt = w_cnt_nxt + CntWidth'(w_busy_nxt[r]);
  end
  // read ports: zero register, optional same-cycle forwarding, then stored data; forced quiet during reset
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int p = 0; p < NRead; p++) begin
      rdata_o[p] = (!rst_ni || raddr_i[p] == '0) ? '0 :
                   (Bypass != 0 && w_wr_hit[raddr_i[p]]) ? w_wr_data[raddr_i[p]] : r_mem[raddr_i[p]];
      rbusy_o[p] = rst_ni && r_busy[raddr_i[p]] && !(Bypass != 0 && w_wr_hit[raddr_i[p]]);
    end
  end
  // storage update; entry 0 never receives a hit so it stays zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_mem <= '0;
    else for (int r = 0; r < NReg; r++) if (w_wr_hit[r]) r_mem[r] <= w_wr_data[r];
  end
  // scoreboard, busy count and sticky collision flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_werr <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
      r_werr <= r_werr | w_werr;
    end
  end
  assign busy_cnt_o = r_cnt;
  assign werr_o     = r_werr;
endmodule
